// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared definitions for the count monitor: FSM state
//                encodings, step-class encodings and the default bus width.
//  Contents    : DEF_WIDTH        default observed count bus width
//                ST_INIT..ST_DOWN 2-bit monitor FSM states
//                SC_HOLD..SC_JUMP 2-bit step classification codes
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    localparam int DEF_WIDTH = 8;

    // Monitor FSM states
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_UP   = 2'd2;
    localparam logic [1:0] ST_DOWN = 2'd3;

    // Step classes derived from delta = cnt_in - prev (mod 2^WIDTH)
    localparam logic [1:0] SC_HOLD = 2'd0;
    localparam logic [1:0] SC_UP   = 2'd1;
    localparam logic [1:0] SC_DOWN = 2'd2;
    localparam logic [1:0] SC_JUMP = 2'd3;

endpackage
`default_nettype wire

// File: rtl/count_step_decode.sv
`default_nettype none
// ============================================================================
//  Module      : count_step_decode
//  Description : Combinational classifier for one observed counter step.
//                Compares the current sample against the previous one and
//                reports the step class, legality and wrap events.
//  Ports       : prev       in   previous sampled count value
//                cnt_in     in   current count value
//                en_in      in   counter enable sampled with cnt_in
//                upstep     out  delta == +1
//                dnstep     out  delta == -1
//                hold       out  delta == 0
//                illegal    out  jump, or any movement while disabled
//                wrap_up    out  enabled +1 step from all-ones to zero
//                wrap_down  out  enabled -1 step from zero to all-ones
//  Revision    : 1.0  initial release
// ============================================================================
module count_step_decode
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             en_in,
    output logic             upstep,
    output logic             dnstep,
    output logic             hold,
    output logic             illegal,
    output logic             wrap_up,
    output logic             wrap_down
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_max  = '1;

    logic [WIDTH-1:0] w_delta;
    logic [1:0]       w_class;

    // Modular difference: a -1 step shows up as all-ones.
    assign w_delta = cnt_in - prev;

    always_comb begin
        w_class = SC_JUMP;
        if (w_delta == c_zero) begin
            w_class = SC_HOLD;
        end else if (w_delta == c_one) begin
            w_class = SC_UP;
        end else if (w_delta == c_max) begin
            w_class = SC_DOWN;
        end
    end

    assign upstep    = (w_class == SC_UP);
    assign dnstep    = (w_class == SC_DOWN);
    assign hold      = (w_class == SC_HOLD);
    assign illegal   = (w_class == SC_JUMP) || (!en_in && (w_class != SC_HOLD));
    assign wrap_up   = upstep && en_in && (prev == c_max);
    assign wrap_down = dnstep && en_in && (prev == c_zero);

endmodule
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : count_monitor
//  Description : Passive observer of an up/down counter output bus. Tracks
//                direction and run length, pulses on wraps and reversals,
//                and records illegal transitions in sticky error state.
//  Ports       : clk        in   system clock, rising edge
//                reset      in   asynchronous active-high reset
//                cnt_in     in   observed count value
//                en_in      in   observed counter enable
//                clr_err    in   synchronous clear of err/err_count/err_value
//                dir_up     out  last accepted step was +1
//                dir_down   out  last accepted step was -1
//                stalled    out  enabled but count unchanged
//                wrap_up    out  one-cycle pulse on max->0 up step
//                wrap_down  out  one-cycle pulse on 0->max down step
//                reversed   out  one-cycle pulse on UP<->DOWN change
//                run_len    out  consecutive same-direction steps (saturating)
//                err        out  sticky error flag
//                err_count  out  error event count (saturating)
//                err_value  out  cnt_in at the most recent error
//  Revision    : 1.0  initial release
// ============================================================================
module count_monitor
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int RUN_W  = 16,
    parameter int ERRC_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              en_in,
    input  logic              clr_err,
    output logic              dir_up,
    output logic              dir_down,
    output logic              stalled,
    output logic              wrap_up,
    output logic              wrap_down,
    output logic              reversed,
    output logic [RUN_W-1:0]  run_len,
    output logic              err,
    output logic [ERRC_W-1:0] err_count,
    output logic [WIDTH-1:0]  err_value
);

    localparam logic [RUN_W-1:0]  c_run_one  = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0]  c_run_max  = '1;
    localparam logic [ERRC_W-1:0] c_errc_one = {{(ERRC_W-1){1'b0}}, 1'b1};
    localparam logic [ERRC_W-1:0] c_errc_max = '1;

    logic [WIDTH-1:0]  r_prev;
    logic [1:0]        r_state;
    logic [RUN_W-1:0]  r_run_len;
    logic              r_stalled;
    logic              r_wrap_up;
    logic              r_wrap_down;
    logic              r_reversed;
    logic              r_err;
    logic [ERRC_W-1:0] r_err_count;
    logic [WIDTH-1:0]  r_err_value;

    logic              w_upstep;
    logic              w_dnstep;
    logic              w_hold;
    logic              w_illegal;
    logic              w_wrap_up;
    logic              w_wrap_down;
    logic              w_active;
    logic              w_err_event;
    logic [RUN_W-1:0]  w_run_inc;
    logic [ERRC_W-1:0] w_errc_inc;

    count_step_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .prev      (r_prev),
        .cnt_in    (cnt_in),
        .en_in     (en_in),
        .upstep    (w_upstep),
        .dnstep    (w_dnstep),
        .hold      (w_hold),
        .illegal   (w_illegal),
        .wrap_up   (w_wrap_up),
        .wrap_down (w_wrap_down)
    );

    // The INIT cycle only seeds prev; nothing is classified against the
    // reset value of prev, so the first sample can never raise an error.
    assign w_active    = (r_state != ST_INIT);
    assign w_err_event = w_active && w_illegal;

    assign w_run_inc  = (r_run_len == c_run_max) ? r_run_len : r_run_len + c_run_one;
    assign w_errc_inc = (r_err_count == c_errc_max) ? r_err_count : r_err_count + c_errc_one;

    // Direction tracking FSM, run length and event pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev      <= '0;
            r_state     <= ST_INIT;
            r_run_len   <= '0;
            r_stalled   <= 1'b0;
            r_wrap_up   <= 1'b0;
            r_wrap_down <= 1'b0;
            r_reversed  <= 1'b0;
        end else begin
            r_prev      <= cnt_in;
            r_stalled   <= 1'b0;
            r_wrap_up   <= 1'b0;
            r_wrap_down <= 1'b0;
            r_reversed  <= 1'b0;
            if (!w_active) begin
                r_state <= ST_IDLE;
            end else begin
                r_stalled   <= en_in && w_hold;
                r_wrap_up   <= w_wrap_up;
                r_wrap_down <= w_wrap_down;
                // Illegal steps leave direction and run length untouched.
                if (!w_illegal) begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_upstep) begin
                                r_state   <= ST_UP;
                                r_run_len <= c_run_one;
                            end else if (w_dnstep) begin
                                r_state   <= ST_DOWN;
                                r_run_len <= c_run_one;
                            end
                        end
                        ST_UP: begin
                            if (w_upstep) begin
                                r_run_len <= w_run_inc;
                            end else if (w_dnstep) begin
                                r_state    <= ST_DOWN;
                                r_run_len  <= c_run_one;
                                r_reversed <= 1'b1;
                            end
                        end
                        ST_DOWN: begin
                            if (w_dnstep) begin
                                r_run_len <= w_run_inc;
                            end else if (w_upstep) begin
                                r_state    <= ST_UP;
                                r_run_len  <= c_run_one;
                                r_reversed <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= ST_INIT;
                        end
                    endcase
                end
            end
        end
    end

    // Error capture; a new error takes priority over a simultaneous clear
    // and restarts the count at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_err_value <= '0;
        end else if (w_err_event) begin
            r_err       <= 1'b1;
            r_err_count <= clr_err ? c_errc_one : w_errc_inc;
            r_err_value <= cnt_in;
        end else if (clr_err) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_err_value <= '0;
        end
    end

    assign dir_up    = (r_state == ST_UP);
    assign dir_down  = (r_state == ST_DOWN);
    assign stalled   = r_stalled;
    assign wrap_up   = r_wrap_up;
    assign wrap_down = r_wrap_down;
    assign reversed  = r_reversed;
    assign run_len   = r_run_len;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign err_value = r_err_value;

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_monitor
//  Description : Self-checking bench for count_monitor: directed vector
//                table, hand-written reset and saturation sequences, and
//                randomized stimulus against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_monitor;

    localparam int WIDTH  = 8;
    localparam int RUN_W  = 16;
    localparam int ERRC_W = 8;
    localparam int c_mod      = 1 << WIDTH;
    localparam int c_run_max  = (1 << RUN_W) - 1;
    localparam int c_errc_max = (1 << ERRC_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  cnt_in;
    logic              en_in;
    logic              clr_err;
    logic              dir_up;
    logic              dir_down;
    logic              stalled;
    logic              wrap_up;
    logic              wrap_down;
    logic              reversed;
    logic [RUN_W-1:0]  run_len;
    logic              err;
    logic [ERRC_W-1:0] err_count;
    logic [WIDTH-1:0]  err_value;

    count_monitor #(
        .WIDTH  (WIDTH),
        .RUN_W  (RUN_W),
        .ERRC_W (ERRC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_in    (cnt_in),
        .en_in     (en_in),
        .clr_err   (clr_err),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .stalled   (stalled),
        .wrap_up   (wrap_up),
        .wrap_down (wrap_down),
        .reversed  (reversed),
        .run_len   (run_len),
        .err       (err),
        .err_count (err_count),
        .err_value (err_value)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic check_outputs(input string tag, input int up, input int dn,
                                 input int st, input int wu, input int wd,
                                 input int rev, input int run, input int er,
                                 input int ec, input int ev);
        cmp({tag, ".dir_up"},    int'(dir_up),    up);
        cmp({tag, ".dir_down"},  int'(dir_down),  dn);
        cmp({tag, ".stalled"},   int'(stalled),   st);
        cmp({tag, ".wrap_up"},   int'(wrap_up),   wu);
        cmp({tag, ".wrap_down"}, int'(wrap_down), wd);
        cmp({tag, ".reversed"},  int'(reversed),  rev);
        cmp({tag, ".run_len"},   int'(run_len),   run);
        cmp({tag, ".err"},       int'(err),       er);
        cmp({tag, ".err_count"}, int'(err_count), ec);
        cmp({tag, ".err_value"}, int'(err_value), ev);
    endtask

    task automatic step(input int c, input bit e, input bit cl);
        cnt_in  = WIDTH'(c);
        en_in   = e;
        clr_err = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: direction is a signed int (-1, 0, +1), deltas are
    // computed with plain modular arithmetic.
    // ------------------------------------------------------------------
    bit m_init;
    int m_prev, m_dir, m_run, m_ecnt, m_eval;
    bit m_err, m_st, m_wu, m_wd, m_rev;

    function automatic void model_reset();
        m_init = 1; m_prev = 0; m_dir = 0; m_run = 0;
        m_err = 0; m_ecnt = 0; m_eval = 0;
        m_st = 0; m_wu = 0; m_wd = 0; m_rev = 0;
    endfunction

    function automatic void model_step(input int c, input bit e, input bit cl);
        int d;
        int s;
        bit bad;
        m_st = 0; m_wu = 0; m_wd = 0; m_rev = 0;
        bad = 0;
        if (m_init) begin
            m_init = 0;
        end else begin
            d = (c - m_prev + c_mod) % c_mod;
            if (d == 0)              s = 0;
            else if (d == 1)         s = 1;
            else if (d == c_mod - 1) s = -1;
            else                     s = 2;
            bad = (s == 2) || (!e && d != 0);
            if (!bad) begin
                if (s == 0) begin
                    m_st = e;
                end else begin
                    if (m_dir == s) begin
                        m_run = (m_run < c_run_max) ? m_run + 1 : c_run_max;
                    end else begin
                        m_rev = (m_dir == -s);
                        m_dir = s;
                        m_run = 1;
                    end
                    m_wu = (s == 1)  && (m_prev == c_mod - 1);
                    m_wd = (s == -1) && (m_prev == 0);
                end
            end
        end
        if (bad) begin
            m_err  = 1;
            m_ecnt = cl ? 1 : ((m_ecnt < c_errc_max) ? m_ecnt + 1 : c_errc_max);
            m_eval = c;
        end else if (cl) begin
            m_err = 0; m_ecnt = 0; m_eval = 0;
        end
        m_prev = c;
    endfunction

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit rst;
        int cnt;
        bit en;
        bit clr;
        int up, dn, st, wu, wd, rev, run, er, ec, ev;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input int c, input bit e, input bit cl,
                                input int up, input int dn, input int st,
                                input int wu, input int wd, input int rev,
                                input int run, input int er, input int ec,
                                input int ev);
        vec_t v;
        v.rst = r; v.cnt = c; v.en = e; v.clr = cl;
        v.up = up; v.dn = dn; v.st = st; v.wu = wu; v.wd = wd; v.rev = rev;
        v.run = run; v.er = er; v.ec = ec; v.ev = ev;
        tbl.push_back(v);
    endfunction

    initial begin
        int last_c;

        reset   = 1'b1;
        cnt_in  = '0;
        en_in   = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        //      rst cnt    en clr  up dn st wu wd rv run er ec ev
        // up run from 0x10
        add(1, 'h10, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h11, 1, 0,   1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 'h12, 1, 0,   1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(0, 'h13, 1, 0,   1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        add(0, 'h14, 1, 0,   1, 0, 0, 0, 0, 0, 4, 0, 0, 0);
        // up wrap
        add(1, 'hFE, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'hFF, 1, 0,   1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 'h00, 1, 0,   1, 0, 0, 1, 0, 0, 2, 0, 0, 0);
        add(0, 'h01, 1, 0,   1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        // reversal
        add(1, 'h20, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h21, 1, 0,   1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 'h22, 1, 0,   1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(0, 'h21, 1, 0,   0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 'h20, 1, 0,   0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
        // jump keeps state, next +1 is legal
        add(1, 'h30, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h31, 1, 0,   1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 'h35, 1, 0,   1, 0, 0, 0, 0, 0, 1, 1, 1, 'h35);
        add(0, 'h36, 1, 0,   1, 0, 0, 0, 0, 0, 2, 1, 1, 'h35);
        // disabled hold, then movement while disabled, then clear
        add(1, 'h40, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h40, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h40, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h40, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h40, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h41, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 1, 'h41);
        add(0, 'h41, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // error coinciding with clear: error wins, count restarts at 1
        add(0, 'h43, 1, 1,   0, 0, 0, 0, 0, 0, 0, 1, 1, 'h43);
        add(0, 'h42, 1, 0,   0, 1, 0, 0, 0, 0, 1, 1, 1, 'h43);
        add(0, 'h42, 1, 0,   0, 1, 1, 0, 0, 0, 1, 1, 1, 'h43);
        add(0, 'h41, 0, 0,   0, 1, 0, 0, 0, 0, 1, 1, 2, 'h41);
        add(0, 'h41, 1, 0,   0, 1, 1, 0, 0, 0, 1, 1, 2, 'h41);
        // down wrap
        add(1, 'h01, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h00, 1, 0,   0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 'hFF, 1, 0,   0, 1, 0, 0, 1, 0, 2, 0, 0, 0);
        add(0, 'hFE, 1, 0,   0, 1, 0, 0, 0, 0, 3, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].cnt, tbl[i].en, tbl[i].clr);
            check_outputs($sformatf("vec%0d", i), tbl[i].up, tbl[i].dn, tbl[i].st,
                          tbl[i].wu, tbl[i].wd, tbl[i].rev, tbl[i].run,
                          tbl[i].er, tbl[i].ec, tbl[i].ev);
        end

        // Reset asserted mid up-run; outputs clear asynchronously.
        do_reset();
        step('h7E, 1, 0);
        step('h7F, 1, 0);
        step('h80, 1, 0);
        check_outputs("mid.pre", 1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_outputs("mid.async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cnt_in = 'h05;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step('h05, 1, 0);
        check_outputs("mid.first", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step('h06, 1, 0);
        check_outputs("mid.second", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Error counter saturation with repeated jumps.
        do_reset();
        step('h00, 1, 0);
        for (int i = 0; i < 300; i++) begin
            step((i % 2 == 0) ? 'h80 : 'h00, 1, 0);
            if (i == 253) cmp("errsat.254", int'(err_count), 254);
        end
        cmp("errsat.count", int'(err_count), c_errc_max);
        cmp("errsat.err",   int'(err),       1);
        cmp("errsat.value", int'(err_value), 'h00);
        cmp("errsat.run",   int'(run_len),   0);

        // Run length saturation with a long up run.
        do_reset();
        step(0, 1, 0);
        for (int i = 1; i <= c_run_max + 5; i++) begin
            step(i % c_mod, 1, 0);
            if (i == c_run_max - 1) cmp("runsat.pre", int'(run_len), c_run_max - 1);
        end
        cmp("runsat.run", int'(run_len), c_run_max);
        cmp("runsat.dir", int'(dir_up),  1);
        cmp("runsat.err", int'(err),     0);

        // Randomized stimulus against the reference model.
        model_reset();
        do_reset();
        last_c = 0;
        for (int i = 0; i < 2000; i++) begin
            int kind;
            int c;
            bit e;
            bit cl;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                model_reset();
            end
            kind = $urandom_range(0, 9);
            if (kind <= 3)      c = (last_c + 1) % c_mod;
            else if (kind <= 5) c = (last_c + c_mod - 1) % c_mod;
            else if (kind <= 7) c = last_c;
            else                c = $urandom_range(0, c_mod - 1);
            e  = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 19) == 0);
            step(c, e, cl);
            model_step(c, e, cl);
            last_c = c;
            check_outputs($sformatf("rnd%0d", i), int'(m_dir == 1), int'(m_dir == -1),
                          int'(m_st), int'(m_wu), int'(m_wd), int'(m_rev), m_run,
                          int'(m_err), m_ecnt, m_eval);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Passive observer at the consuming end of the 8-bit up/down counter output bus.
- Samples the count value and the enable strobe each clock, then decodes direction, run length and wrap events.
- Flags illegal transitions (jumps, or movement while disabled).
- Used in-system as a health checker and as a self-checking monitor in counter benches.

Parameters:
- WIDTH, 8, width of observed count bus.
- RUN_W, 16, width of run-length counter (saturating).
- ERRC_W, 8, width of error counter (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cnt_in  input  WIDTH  observed count value.
- en_in  input  1  observed counter enable, sampled with cnt_in.
- clr_err  input  1  synchronous clear of err, err_count and err_value.
- dir_up  output  1  last accepted step was +1.
- dir_down  output  1  last accepted step was -1.
- stalled  output  1  en_in=1 but cnt_in unchanged this cycle.
- wrap_up  output  1  one-cycle pulse on a max->0 up step.
- wrap_down  output  1  one-cycle pulse on a 0->max down step.
- reversed  output  1  one-cycle pulse on a direction change UP<->DOWN.
- run_len  output  RUN_W  consecutive same-direction steps.
- err  output  1  sticky error flag.
- err_count  output  ERRC_W  number of error events, saturating.
- err_value  output  WIDTH  cnt_in at the most recent error.

Behaviour:
- Reset (async, active-high) sets all outputs to 0, state=INIT, prev=0.
- Internal registers: prev (last cnt_in), state.
- delta = (cnt_in - prev) mod 2^WIDTH.
- Step classification, evaluated each cycle when state!=INIT:
  - UPSTEP: delta==1.
  - DNSTEP: delta==2^WIDTH-1.
  - HOLD: delta==0.
  - JUMP: any other delta.
- Illegal condition: JUMP, or en_in==0 with delta!=0.
- On an illegal condition:
  - err<=1.
  - err_count increments (saturates at all-ones).
  - err_value<=cnt_in.
  - state and run_len are not updated by a JUMP; prev still updates.
- FSM states: INIT, IDLE, UP, DOWN.
  - INIT: capture prev<=cnt_in, go to IDLE. No classification and no flags in this cycle.
  - IDLE: UPSTEP->UP with run_len=1; DNSTEP->DOWN with run_len=1; HOLD stays.
  - UP: UPSTEP stays, run_len+1; DNSTEP->DOWN with run_len=1 and reversed pulse; HOLD stays, run_len held.
  - DOWN: mirror of UP.
- A legal step with en_in==0 cannot occur, because it is illegal by definition. An illegal step does not change state.
- dir_up=(state==UP), dir_down=(state==DOWN).
- wrap_up: UPSTEP with prev==all-ones. wrap_down: DNSTEP with prev==0. Both require en_in==1.
- stalled: en_in==1 and HOLD, with state!=INIT.
- Latency:
  - All outputs are registered, valid one clock after the edge that samples the second value of a pair.
  - Pulses last exactly one cycle.
- run_len saturates at 2^RUN_W-1 and does not wrap.
- clr_err clears err, err_count and err_value next edge.
- If clr_err coincides with an error event, the error wins: err=1, err_count=1, err_value=cnt_in.
- Reset asserted mid-run returns to INIT. The first sample after release never raises err.

Decomposition:
- Shared package counter_pkg holds:
  - state enum/localparams ST_INIT, ST_IDLE, ST_UP, ST_DOWN (2-bit);
  - default WIDTH=8;
  - step-class encodings.
- One natural sub-module: count_step_decode, a combinational classifier (prev, cnt_in, en_in -> upstep, dnstep, hold, illegal, wrap_up, wrap_down).
- FSM and counters stay in count_monitor.

Test Plan:
- Reset, then cnt_in stepping 0x10..0x14 with en_in=1 -> dir_up=1, run_len=4 after the last step, err=0.
- Up run to 0xFF then 0x00 -> single wrap_up pulse, run_len continues incrementing, err=0.
- Up 0x20->0x21->0x22, then down to 0x21 -> reversed pulse, dir_down=1, run_len=1. Then 0x21->0x20 gives run_len=2.
- Jump 0x30->0x35 with en_in=1 -> err=1, err_count=1, err_value=0x35, state unchanged. Then 0x35->0x36 is legal.
- en_in=0 with cnt_in held at 0x40 for 5 cycles -> no err, stalled=0. Then en_in=0 with 0x41 -> err=1, err_count increments. clr_err with no error -> err=0, err_count=0.
- Reset mid-up-run at 0x80, release with cnt_in=0x05 -> all outputs 0, no err, next 0x06 gives dir_up=1, run_len=1.
